// File: rtl/ecc_fifo_ctrl.sv
// ecc_fifo_ctrl
//   Pointer and flag controller for the 39-bit x 16-entry ECC FIFO storage
//   array. It never touches data bits. It only produces the array's write and
//   read enables and addresses, tracks occupancy, and generates the flags and a
//   read-valid strobe aligned to the array's registered read data.
//
//   Optional feature macro: ECC_FIFO_ERR_FLAGS_EN
//     defined   -> sticky overflow/underflow flags, cleared by err_clr
//     undefined -> overflow/underflow tied low, err_clr ignored
//
// Ports
//   clk           system clock (rising edge)
//   rst_n         asynchronous active-low reset
//   push, pop     write / read requests
//   push_ok       push accepted this cycle (combinational)
//   pop_ok        pop accepted this cycle (combinational)
//   mem_wr_en     array write enable
//   mem_wr_addr   array write address (current write pointer)
//   mem_rd_en     array read enable
//   mem_rd_addr   array read address (current read pointer)
//   rd_valid      array read word is valid this cycle (registered)
//   full, empty, almost_full, almost_empty   occupancy flags
//   count         occupancy 0..2**ADDR_W
//   overflow      sticky: push was rejected
//   underflow     sticky: pop was issued while empty
//   err_clr       clears overflow/underflow
module ecc_fifo_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   output logic              push_ok,
   output logic              pop_ok,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              rd_valid_q, rd_valid_d;

   // Flags come straight from the registered count, with no added latency.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;

   // Empty is evaluated before this cycle's push, so there is no fall-through.
   // When full, a push is accepted only alongside an accepted pop. The array
   // then reads the old word at the shared address before overwriting it.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   assign mem_wr_en   = push_ok;
   assign mem_wr_addr = wr_ptr_q;
   assign mem_rd_en   = pop_ok;
   assign mem_rd_addr = rd_ptr_q;
   assign rd_valid    = rd_valid_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = pop_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef ECC_FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // A set event takes priority over a coincident clear.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (push & ~push_ok) overflow_d = 1'b1;
      else if (err_clr)    overflow_d = 1'b0;
      if (pop & empty)     underflow_d = 1'b1;
      else if (err_clr)    underflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_fifo_ctrl.sv
module tb_ecc_fifo_ctrl;

`ifdef ECC_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       push, pop, err_clr;
   logic       push_ok, pop_ok, mem_wr_en, mem_rd_en, rd_valid;
   logic [3:0] mem_wr_addr, mem_rd_addr;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   ecc_fifo_ctrl #(.ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
      .push_ok(push_ok), .pop_ok(pop_ok),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Storage array emulation: registered read, read-before-write.
   int arr [DEPTH];
   int rd_word;
   int drive_wid;
   always @(posedge clk) begin
      if (mem_rd_en) rd_word <= arr[mem_rd_addr];
      if (mem_wr_en) arr[mem_wr_addr] <= drive_wid;
   end

   // Reference model: a queue of word ids plus total push/pop tallies.
   int  q[$];
   int  n_push, n_pop, next_id;
   bit  exp_rv;
   int  exp_rv_id;
   bit  m_ovf, m_unf;
   int  ncmp, nfail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      n_push = 0; n_pop = 0;
      exp_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic chk_flags(input string pfx);
      int c;
      c = q.size();
      chk({pfx, "count"},        32'(count),        32'(c));
      chk({pfx, "full"},         32'(full),         32'(c == DEPTH));
      chk({pfx, "empty"},        32'(empty),        32'(c == 0));
      chk({pfx, "almost_full"},  32'(almost_full),  32'(c >= 14));
      chk({pfx, "almost_empty"}, 32'(almost_empty), 32'(c <= 2));
      chk({pfx, "wr_addr"},      32'(mem_wr_addr),  32'(n_push % DEPTH));
      chk({pfx, "rd_addr"},      32'(mem_rd_addr),  32'(n_pop % DEPTH));
      chk({pfx, "rd_valid"},     32'(rd_valid),     32'(exp_rv));
      chk({pfx, "overflow"},     32'(overflow),     32'(m_ovf));
      chk({pfx, "underflow"},    32'(underflow),    32'(m_unf));
   endtask

   task automatic step(input bit p, input bit r, input bit c);
      bit e_pop, e_push;
      int cnt;
      @(negedge clk);
      push = p; pop = r; err_clr = c;
      drive_wid = next_id;
      #1;
      cnt    = q.size();
      e_pop  = r && (cnt != 0);
      e_push = p && ((cnt != DEPTH) || e_pop);
      chk_flags("");
      if (exp_rv) chk("rd_word", 32'(rd_word), 32'(exp_rv_id));
      chk("push_ok",   32'(push_ok),   32'(e_push));
      chk("pop_ok",    32'(pop_ok),    32'(e_pop));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(e_push));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(e_pop));
      @(posedge clk);
      exp_rv = e_pop;
      if (e_pop) begin
         exp_rv_id = q.pop_front();
         n_pop++;
      end
      if (e_push) begin
         q.push_back(next_id);
         next_id++;
         n_push++;
      end
      if (ERR_EN) begin
         if (p && !e_push) m_ovf = 1'b1;
         else if (c)       m_ovf = 1'b0;
         if (r && cnt == 0) m_unf = 1'b1;
         else if (c)        m_unf = 1'b0;
      end
   endtask

   initial begin
      ncmp = 0; nfail = 0; next_id = 100; drive_wid = 0; rd_word = 0;
      push = 0; pop = 0; err_clr = 0; rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_flags("rst_");
      @(negedge clk);
      rst_n = 1;

      // Fill: 16 pushes, then a rejected 17th.
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 1);
      // Drain: 16 pops, then a rejected extra pop.
      for (int i = 0; i < 16; i++) step(0, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(1, 1, 0);
      step(1, 1, 0);
      for (int i = 0; i < 17; i++) step(0, 1, 0);

      // Empty with simultaneous push and pop: no fall-through.
      step(1, 1, 0);
      step(0, 0, 0);
      step(0, 1, 1);

      // Wrap: interleaved push/pop walks pointers across 15 -> 0.
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 0);
      for (int i = 0; i < 20; i++) step(i % 2 == 0, i % 2 == 1, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0);

      // Randomized traffic, including occasional error clears.
      for (int i = 0; i < 400; i++) begin
         bit p, r;
         p = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
         r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
         step(p, r, ($urandom_range(0, 7) == 0));
      end

      // Reset mid-burst while a read strobe is in flight.
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(1, 1, 0);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      chk_flags("midrst_");
      push = 0; pop = 0; err_clr = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      step(0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
